// File: rtl/prog_clock_divider_if.sv
// prog_clock_divider_if: control/status bundle for prog_clock_divider; sync_in exists only with PCD_SYNC_EN
interface prog_clock_divider_if #(
  parameter int DIV_W = 26
);
  logic             en;
  logic [DIV_W-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic             div_pending;
`ifdef PCD_SYNC_EN
  logic             sync_in;
  modport master (output en, div_in, div_load, sync_in, input clk_out, tick, div_pending);
  modport slave (input en, div_in, div_load, sync_in, output clk_out, tick, div_pending);
`else
  modport master (output en, div_in, div_load, input clk_out, tick, div_pending);
  modport slave (input en, div_in, div_load, output clk_out, tick, div_pending);
`endif
endinterface

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: programmable clock divider with period tick; optional sync restart via PCD_SYNC_EN
module prog_clock_divider #(
  parameter int DIV_W       = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input logic                clk_in,
  input logic                nReset,
  prog_clock_divider_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, per, per_n, shadow, shadow_n, clamped;
  logic             pend, pend_n, clk_q, clk_n, tick_q, tick_n, sync, restart, apply;
`ifdef PCD_SYNC_EN
  assign sync = bus.sync_in;
`else
  assign sync = 1'b0;
`endif
  assign bus.clk_out     = clk_q;
  assign bus.tick        = tick_q;
  assign bus.div_pending = pend;
  // period restarts on enable from IDLE, on wrap, or on sync; a pending divisor is applied only then
  always_comb begin
    clamped  = (bus.div_in < DIV_W'(2)) ? DIV_W'(2) : bus.div_in;
    restart  = bus.en && (state == IDLE || cnt == per - DIV_W'(1) || sync);
    apply    = restart && pend;
    state_n  = bus.en ? RUN : IDLE;
    per_n    = apply ? shadow : per;
    shadow_n = bus.div_load ? clamped : shadow;
    pend_n   = bus.div_load || (pend && !apply);
    cnt_n    = (!bus.en || restart) ? '0 : cnt + DIV_W'(1);
    clk_n    = bus.en && (cnt_n < (per_n >> 1));
    tick_n   = bus.en && (cnt_n == '0);
  end
  // state and registered outputs; reset restores the default period immediately
  always_ff @(posedge clk_in or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      cnt    <= '0;
      per    <= DIV_W'(DEFAULT_DIV);
      shadow <= DIV_W'(DEFAULT_DIV);
      pend   <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      per    <= per_n;
      shadow <= shadow_n;
      pend   <= pend_n;
      clk_q  <= clk_n;
      tick_q <= tick_n;
    end
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
// tb_prog_clock_divider: directed scoreboard bench for prog_clock_divider with DEFAULT_DIV=10
module tb_prog_clock_divider;
  localparam int DIV_W = 26;
  typedef struct {
    logic [2:0] v;
    string      tag;
  } exp_t;
  logic  clk = 1'b0;
  logic  nReset;
  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$];
  prog_clock_divider_if #(.DIV_W(DIV_W)) bus ();
  prog_clock_divider #(.DIV_W(DIV_W), .DEFAULT_DIV(10)) dut (
    .clk_in(clk),
    .nReset(nReset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // expected {clk_out, tick, div_pending}
  task automatic push(input logic [2:0] v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    sb.push_back(e);
  endtask
  task automatic check_now();
    exp_t       e;
    logic [2:0] obs;
    obs = {bus.clk_out, bus.tick, bus.div_pending};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%b", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    check_now();
  endtask
  // one output cycle at phase i of a period of length p: high for p/2 cycles, tick at phase 0
  task automatic cyc(input int p, input int i, input logic pend, input string tag);
    push({logic'(i < p / 2), logic'(i == 0), pend}, tag);
    step();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    nReset = 1'b0;
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in = '0;
`ifdef PCD_SYNC_EN
    bus.sync_in = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    push(3'b000, "reset");
    step();
    nReset = 1'b1;
    push(3'b000, "idle");
    step();
    bus.en = 1'b1;
    for (int k = 0; k < 20; k++) cyc(10, k % 10, 1'b0, "p10");
    for (int i = 0; i < 3; i++) cyc(10, i, 1'b0, "p10b");
    bus.div_load = 1'b1;
    bus.div_in = 4;
    cyc(10, 3, 1'b1, "load4");
    bus.div_load = 1'b0;
    for (int i = 4; i < 10; i++) cyc(10, i, 1'b1, "p10_pend");
    for (int k = 0; k < 8; k++) cyc(4, k % 4, 1'b0, "p4");
    cyc(4, 0, 1'b0, "p4b");
    bus.div_load = 1'b1;
    bus.div_in = 1;
    cyc(4, 1, 1'b1, "load1");
    bus.div_load = 1'b0;
    cyc(4, 2, 1'b1, "p4_pend");
    cyc(4, 3, 1'b1, "p4_pend");
    for (int k = 0; k < 6; k++) cyc(2, k % 2, 1'b0, "p2_clamp");
    bus.div_load = 1'b1;
    bus.div_in = 7;
    cyc(2, 0, 1'b1, "load_on_wrap");
    bus.div_load = 1'b0;
    cyc(2, 1, 1'b1, "p2_pend");
    for (int k = 0; k < 7; k++) cyc(7, k, 1'b0, "p7");
    cyc(7, 0, 1'b0, "p7b");
    bus.div_load = 1'b1;
    bus.div_in = 6;
    cyc(7, 1, 1'b1, "load6");
    bus.div_load = 1'b0;
    cyc(7, 2, 1'b1, "p7_pend");
    bus.div_load = 1'b1;
    bus.div_in = 8;
    cyc(7, 3, 1'b1, "load8");
    bus.div_load = 1'b0;
    for (int i = 4; i < 7; i++) cyc(7, i, 1'b1, "p7_pend2");
    for (int k = 0; k < 16; k++) cyc(8, k % 8, 1'b0, "p8");
    for (int i = 0; i < 3; i++) cyc(8, i, 1'b0, "p8b");
    bus.en = 1'b0;
    push(3'b000, "en_off");
    step();
    bus.div_load = 1'b1;
    bus.div_in = 5;
    push(3'b001, "idle_load");
    step();
    bus.div_load = 1'b0;
    push(3'b001, "idle_pend");
    step();
    bus.en = 1'b1;
    for (int k = 0; k < 10; k++) cyc(5, k % 5, 1'b0, "p5_reenable");
    for (int i = 0; i < 3; i++) cyc(5, i, 1'b0, "p5b");
    nReset = 1'b0;
    #1;
    push(3'b000, "async_reset");
    check_now();
    #1;
    nReset = 1'b1;
    for (int k = 0; k < 12; k++) cyc(10, k % 10, 1'b0, "after_reset");
`ifdef PCD_SYNC_EN
    cyc(10, 2, 1'b0, "pre_sync");
    bus.sync_in = 1'b1;
    cyc(10, 0, 1'b0, "sync");
    bus.sync_in = 1'b0;
    for (int i = 1; i < 10; i++) cyc(10, i, 1'b0, "post_sync");
    cyc(10, 0, 1'b0, "sync_next_tick");
    bus.div_load = 1'b1;
    bus.div_in = 4;
    cyc(10, 1, 1'b1, "sync_load");
    bus.div_load = 1'b0;
    bus.sync_in = 1'b1;
    cyc(4, 0, 1'b0, "sync_apply");
    bus.sync_in = 1'b0;
    for (int i = 1; i < 4; i++) cyc(4, i, 1'b0, "sync_p4");
`endif
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
